serial_tx: RTL and testbench

- Parallel-in, serial-out framed transmitter: start bit, DATA_WIDTH data bits LSB first, optional even-parity bit, stop bit.
- Drives a single-bit line. That line is sampled at the far end by a bit-timed D-flip-flop/shift-register receiver in the lab sequential-logic set.
- Provides the driving end of the D-sampled serial interface; also used as a stimulus source in later labs.

---
 rtl/serial_pkg.sv | 17 +
 rtl/bit_timer.sv | 37 +++
 rtl/serial_tx.sv | 127 ++++++++++++
 tb/tb_serial_tx.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the framed serial link: FSM state encoding and line levels.
// The receiver side reuses these so both ends agree on frame structure.
package serial_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   localparam logic LINE_IDLE  = 1'b1;
   localparam logic LINE_START = 1'b0;
   localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: Tick is high on the last cycle of each CLKS_PER_BIT-cycle period.
// Clear restarts the count so the first period after Clear is a full one.
module bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic Clock,
   input  logic Reset,
   input  logic Clear,
   output logic Tick
);

   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

   logic [TW-1:0] cnt_q;
   logic [TW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (Clear || (cnt_q == LAST)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + TW'(1);
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign Tick = (cnt_q == LAST);

endmodule

// File: rtl/serial_tx.sv
// Framed serial transmitter: start bit, LSB-first data, optional even parity, stop bit.
// All outputs are registered; Start is only honoured while idle (never queued).
module serial_tx
   import serial_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 0
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Start,
   input  logic [DATA_WIDTH-1:0] Data,
   output logic                  TxOut,
   output logic                  Busy,
   output logic                  Done
);

   localparam int CW = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   tx_state_e             state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
   logic                  parity_q, parity_d;
   logic                  tx_q, tx_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  tick;
   logic                  timer_clear;

   // Holding the timer cleared while idle makes the start bit a full period.
   assign timer_clear = (state_q == ST_IDLE);

   bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .Clock(Clock),
      .Reset(Reset),
      .Clear(timer_clear),
      .Tick (tick)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      parity_d  = parity_q;
      done_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               state_d   = ST_START;
               shift_d   = Data;
               parity_d  = ^Data;
               bit_cnt_d = '0;
            end
         end
         ST_START: begin
            if (tick) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (tick) begin
               shift_d = shift_q >> 1;
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d = '0;
                  state_d   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + CW'(1);
               end
            end
         end
         ST_PARITY: begin
            if (tick) begin
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (tick) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are derived from the next state so they change together with it.
      case (state_d)
         ST_START:  tx_d = LINE_START;
         ST_DATA:   tx_d = shift_d[0];
         ST_PARITY: tx_d = parity_d;
         ST_STOP:   tx_d = LINE_STOP;
         default:   tx_d = LINE_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         parity_q  <= 1'b0;
         tx_q      <= LINE_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         parity_q  <= parity_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign TxOut = tx_q;
   assign Busy  = busy_q;
   assign Done  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: three configurations (4 clk/bit, 4 clk/bit + parity, 1 clk/bit)
// compared cycle by cycle against a frame model built from the data word.
module tb_serial_tx;

   logic       clk;
   logic       rst;
   logic       start [3];
   logic [7:0] data  [3];
   logic       tx    [3];
   logic       busy  [3];
   logic       done  [3];

   int n_assert;
   int n_fail;
   logic exp_wave[$];

   serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u_dut_a (
      .Clock(clk), .Reset(rst), .Start(start[0]), .Data(data[0]),
      .TxOut(tx[0]), .Busy(busy[0]), .Done(done[0]));

   serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_dut_p (
      .Clock(clk), .Reset(rst), .Start(start[1]), .Data(data[1]),
      .TxOut(tx[1]), .Busy(busy[1]), .Done(done[1]));

   serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) u_dut_1 (
      .Clock(clk), .Reset(rst), .Start(start[2]), .Data(data[2]),
      .TxOut(tx[2]), .Busy(busy[2]), .Done(done[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int cpb_of(input int d);
      return (d == 2) ? 1 : 4;
   endfunction

   function automatic bit par_of(input int d);
      return (d == 1);
   endfunction

   // Line waveform of one frame, one entry per busy cycle.
   task automatic build_wave(input int d, input logic [7:0] v);
      logic bits[$];
      int   ones;
      ones = 0;
      exp_wave.delete();
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) begin
         bits.push_back(v[i]);
         ones += int'(v[i]);
      end
      if (par_of(d)) bits.push_back((ones % 2) == 1);
      bits.push_back(1'b1);
      foreach (bits[b])
         for (int c = 0; c < cpb_of(d); c++) exp_wave.push_back(bits[b]);
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input int d, input string tag, input logic exp_done);
      chk($sformatf("%s d%0d tx", tag, d), tx[d], 1'b1);
      chk($sformatf("%s d%0d busy", tag, d), busy[d], 1'b0);
      chk($sformatf("%s d%0d done", tag, d), done[d], exp_done);
   endtask

   // Sends one frame on DUT d. ign_at: cycle at which a competing Start is pulsed;
   // rst_at: cycle at which Reset is asserted to abandon the frame (-1 = none).
   task automatic send_frame(input int d, input logic [7:0] val, input int ign_at,
                             input logic [7:0] ign_val, input int rst_at);
      build_wave(d, val);
      data[d]  = val;
      start[d] = 1'b1;
      @(negedge clk);
      start[d] = 1'b0;
      for (int k = 0; k < exp_wave.size(); k++) begin
         chk($sformatf("d%0d v%02h tx k%0d", d, val, k), tx[d], exp_wave[k]);
         chk($sformatf("d%0d v%02h busy k%0d", d, val, k), busy[d], 1'b1);
         chk($sformatf("d%0d v%02h done k%0d", d, val, k), done[d], 1'b0);
         if (k == rst_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk_idle(d, "midrst", 1'b0);
            @(negedge clk);
            chk_idle(d, "midrst_after", 1'b0);
            return;
         end
         if (k == ign_at) begin
            start[d] = 1'b1;
            data[d]  = ign_val;
         end else if (k == ign_at + 1) begin
            start[d] = 1'b0;
            data[d]  = ~val;
         end
         @(negedge clk);
      end
      start[d] = 1'b0;
      chk_idle(d, $sformatf("d%0d v%02h done_cycle", d, val), 1'b1);
      @(negedge clk);
      chk_idle(d, $sformatf("d%0d v%02h post_done", d, val), 1'b0);
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst      = 1'b1;
      for (int d = 0; d < 3; d++) begin
         start[d] = 1'b1;
         data[d]  = 8'hFF;
      end

      // Reset held with Start asserted: nothing may start.
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) chk_idle(d, "reset", 1'b0);
      end
      rst = 1'b0;
      for (int d = 0; d < 3; d++) start[d] = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 3; d++) chk_idle(d, "after_reset", 1'b0);

      // Basic, parity and single-clock-per-bit frames.
      send_frame(0, 8'hA5, -1, 8'h00, -1);
      send_frame(1, 8'hA5, -1, 8'h00, -1);
      send_frame(1, 8'h07, -1, 8'h00, -1);
      send_frame(2, 8'hA5, -1, 8'h00, -1);

      // Start while busy is ignored.
      send_frame(0, 8'hA5, 10, 8'h3C, -1);

      // Back-to-back frames with Start held high.
      build_wave(0, 8'h00);
      data[0]  = 8'h00;
      start[0] = 1'b1;
      @(negedge clk);
      for (int f = 0; f < 3; f++) begin
         for (int k = 0; k < exp_wave.size(); k++) begin
            chk($sformatf("b2b f%0d tx k%0d", f, k), tx[0], exp_wave[k]);
            chk($sformatf("b2b f%0d busy k%0d", f, k), busy[0], 1'b1);
            chk($sformatf("b2b f%0d done k%0d", f, k), done[0], 1'b0);
            @(negedge clk);
         end
         chk_idle(0, $sformatf("b2b f%0d gap", f), 1'b1);
         if (f == 2) start[0] = 1'b0;
         @(negedge clk);
      end
      chk_idle(0, "b2b end", 1'b0);

      // Mid-frame reset, then a full frame afterwards.
      send_frame(0, 8'hC3, -1, 8'h00, 15);
      send_frame(0, 8'h5A, -1, 8'h00, -1);
      send_frame(2, 8'h81, -1, 8'h00, 4);
      send_frame(2, 8'h3E, -1, 8'h00, -1);

      // Randomized frames across all configurations.
      for (int i = 0; i < 15; i++) begin
         int         d;
         logic [7:0] v;
         logic [7:0] iv;
         int         ig;
         d  = int'($urandom_range(0, 2));
         v  = 8'($urandom);
         iv = 8'($urandom);
         ig = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 8 * cpb_of(d))) : -1;
         send_frame(d, v, ig, iv, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
